// File: rtl/l2_fill_arbiter_pkg.sv
// Shared types for the L2 line-fill arbiter.
// Fill FSM state and requester id encodings.
package l2_fill_arbiter_pkg;

  localparam int DATA_W = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_WAIT  = 2'd2,
    ST_BURST = 2'd3
  } fill_state_e;

  typedef enum logic {
    REQ_IC = 1'b0,
    REQ_DC = 1'b1
  } req_id_e;

  function automatic req_id_e other_side(
    input req_id_e id
  );
    return (id == REQ_IC) ? REQ_DC : REQ_IC;
  endfunction

endpackage

// File: rtl/l2_fill_arbiter_if.sv
// Cache/L2 side bundle of the fill arbiter.
// slave: arbiter view; master: caches + L2 view.
interface l2_fill_arbiter_if #(
  parameter int ADDR_W = 32
);
  import l2_fill_arbiter_pkg::*;

  logic              ic_req_i;
  logic [ADDR_W-1:0] ic_addr_i;
  logic              dc_req_i;
  logic [ADDR_W-1:0] dc_addr_i;
  logic              ic_grant_o;
  logic              dc_grant_o;
  logic              ic_done_o;
  logic              dc_done_o;
  logic              l2_req_o;
  logic [ADDR_W-1:0] l2_addr_o;
  logic              l2_ack_i;
  logic              l2_rvalid_i;
  logic [DATA_W-1:0] l2_rdata_i;
  logic [DATA_W-1:0] fill_data_o;
  logic              err_o;

  modport slave (
    input  ic_req_i,
    input  ic_addr_i,
    input  dc_req_i,
    input  dc_addr_i,
    input  l2_ack_i,
    input  l2_rvalid_i,
    input  l2_rdata_i,
    output ic_grant_o,
    output dc_grant_o,
    output ic_done_o,
    output dc_done_o,
    output l2_req_o,
    output l2_addr_o,
    output fill_data_o,
    output err_o
  );

  modport master (
    output ic_req_i,
    output ic_addr_i,
    output dc_req_i,
    output dc_addr_i,
    output l2_ack_i,
    output l2_rvalid_i,
    output l2_rdata_i,
    input  ic_grant_o,
    input  dc_grant_o,
    input  ic_done_o,
    input  dc_done_o,
    input  l2_req_o,
    input  l2_addr_o,
    input  fill_data_o,
    input  err_o
  );

endinterface

// File: rtl/l2_fill_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter, combinational.
// req_i[0]=IC, req_i[1]=DC; ptr_i picks the tie winner.
module rr_arbiter2
  import l2_fill_arbiter_pkg::*;
(
  input  logic [1:0] req_i,
  input  req_id_e    ptr_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = 2'b00;
    if (&req_i) begin
      gnt_o = (ptr_i == REQ_DC) ? 2'b10 : 2'b01;
    end else begin
      gnt_o = req_i;
    end
  end

endmodule

// File: rtl/l2_fill_arbiter.sv
// L2 line-fill arbiter: picks IC or DC miss, runs one
// L2 burst and steers its beats to the owning cache.
module l2_fill_arbiter
  import l2_fill_arbiter_pkg::*;
#(
  parameter int BEATS  = 8,
  parameter int ADDR_W = 32
) (
  input logic         clk_i,
  input logic         reset_ni,
  l2_fill_arbiter_if.slave bus
);

  localparam int CNT_W =
    (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(BEATS - 1);

  fill_state_e       state_q, state_d;
  req_id_e           owner_q, owner_d;
  req_id_e           ptr_q, ptr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic [1:0] req_vec;
  logic [1:0] gnt_vec;
  logic       beat_ok;

  assign req_vec = {bus.dc_req_i, bus.ic_req_i};

  rr_arbiter2 u_arb (
    .req_i (req_vec),
    .ptr_i (ptr_q),
    .gnt_o (gnt_vec)
  );

  assign beat_ok = bus.l2_rvalid_i &&
    ((state_q == ST_WAIT) ||
     (state_q == ST_BURST));

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // The finishing side still holds its request
        // in the done cycle; skip arbitration there.
        if (!done_q && (|req_vec)) begin
          owner_d = gnt_vec[1] ? REQ_DC : REQ_IC;
          addr_d  = gnt_vec[0] ? bus.ic_addr_i
                               : bus.dc_addr_i;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (bus.l2_ack_i) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT, ST_BURST: begin
        if (bus.l2_rvalid_i) begin
          if (cnt_q == LAST) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            done_d  = 1'b1;
            ptr_d   = other_side(owner_q);
          end else begin
            state_d = ST_BURST;
            cnt_d   = cnt_q + 1'b1;
          end
        end else if (state_q == ST_BURST) begin
          // Broken burst: drop it, keep the pointer so
          // the same side can win again.
          state_d = ST_IDLE;
          cnt_d   = '0;
          err_d   = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= ST_IDLE;
      owner_q <= REQ_IC;
      ptr_q   <= REQ_IC;
      addr_q  <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bus.l2_req_o    = (state_q == ST_REQ);
  assign bus.l2_addr_o   = addr_q;
  assign bus.fill_data_o = bus.l2_rdata_i;
  assign bus.ic_grant_o  = beat_ok &&
                           (owner_q == REQ_IC);
  assign bus.dc_grant_o  = beat_ok &&
                           (owner_q == REQ_DC);
  assign bus.ic_done_o   = done_q &&
                           (owner_q == REQ_IC);
  assign bus.dc_done_o   = done_q &&
                           (owner_q == REQ_DC);
  assign bus.err_o       = err_q;

endmodule

// File: tb/tb_l2_fill_arbiter.sv
// Self-checking bench for l2_fill_arbiter.
// Vector table of fills plus hand-written corner cases.
module tb_l2_fill_arbiter;

  localparam int BEATS = 8;

  typedef struct {
    bit          ic;
    bit          dc;
    logic [31:0] ic_addr;
    logic [31:0] dc_addr;
    int          ack;
    bit          first_dc;
  } fill_vec_t;

  typedef struct {
    bit          id;
    logic [31:0] addr;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_err    = 0;
  int   g_cnt[2] = '{0, 0};
  int   d_cnt[2] = '{0, 0};
  int   e_cnt    = 0;
  int   oh_viol  = 0;
  exp_t sb[$];
  fill_vec_t vec[7];

  l2_fill_arbiter_if #(.ADDR_W(32)) bus ();

  l2_fill_arbiter #(
    .BEATS  (BEATS),
    .ADDR_W (32)
  ) dut (
    .clk_i    (clk),
    .reset_ni (rst_n),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.ic_grant_o) g_cnt[0]++;
    if (bus.dc_grant_o) g_cnt[1]++;
    if (bus.ic_done_o)  d_cnt[0]++;
    if (bus.dc_done_o)  d_cnt[1]++;
    if (bus.err_o)      e_cnt++;
    if (bus.ic_grant_o && bus.dc_grant_o) oh_viol++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: no finish by %0t", $time);
    $fatal(1);
  end

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic clk_step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic gnt_of(input bit id);
    return id ? bus.dc_grant_o : bus.ic_grant_o;
  endfunction

  function automatic logic done_of(input bit id);
    return id ? bus.dc_done_o : bus.ic_done_o;
  endfunction

  task automatic drop(input bit id);
    if (id) bus.dc_req_i = 1'b0;
    else    bus.ic_req_i = 1'b0;
  endtask

  // L2 model for one burst; pops the expected owner.
  task automatic serve(input int ack_dly,
                       input int gap_after,
                       input int raise_dc,
                       input int drop_at,
                       output bit aborted);
    exp_t e;
    bit got;
    int g0[2];
    int d0[2];
    logic [63:0] dat;
    aborted = 1'b0;
    if (sb.size() == 0) begin
      chk("sb_empty", 64'd0, 64'd1);
      return;
    end
    e = sb.pop_front();
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      #1;
      if (bus.l2_req_o) got = 1'b1;
      else clk_step();
    end
    if (!got) begin
      chk("l2_req_timeout", 64'd0, 64'd1);
      return;
    end
    chk("l2_addr", 64'(bus.l2_addr_o), 64'(e.addr));
    g0 = g_cnt;
    d0 = d_cnt;
    bus.l2_rvalid_i = 1'b1;
    #1;
    chk("rvalid_in_req_gnt",
        {bus.ic_grant_o, bus.dc_grant_o}, 64'd0);
    bus.l2_rvalid_i = 1'b0;
    for (int i = 0; i < ack_dly; i++) begin
      clk_step();
      chk("req_hold", 64'(bus.l2_req_o), 64'd1);
      chk("addr_hold", 64'(bus.l2_addr_o),
          64'(e.addr));
    end
    bus.l2_ack_i = 1'b1;
    clk_step();
    bus.l2_ack_i = 1'b0;
    for (int b = 0; b < BEATS; b++) begin
      if (b == raise_dc) bus.dc_req_i = 1'b1;
      if (b == drop_at) drop(e.id);
      if (gap_after >= 0 && b == gap_after + 1) begin
        bus.l2_rvalid_i = 1'b0;
        #1;
        chk("gap_gnt", 64'(gnt_of(e.id)), 64'd0);
        clk_step();
        chk("gap_err", 64'(bus.err_o), 64'd1);
        chk("gap_done", 64'(done_of(e.id)), 64'd0);
        chk("gap_beats", 64'(g_cnt[e.id] - g0[e.id]),
            64'(gap_after + 1));
        #1;
        aborted = 1'b1;
        return;
      end
      dat = {e.addr, 32'(b)} ^ 64'h5a5a_0000_c3c3_0000;
      bus.l2_rvalid_i = 1'b1;
      bus.l2_rdata_i  = dat;
      #1;
      chk("fill_data", bus.fill_data_o, dat);
      chk("own_gnt", 64'(gnt_of(e.id)), 64'd1);
      chk("oth_gnt", 64'(gnt_of(!e.id)), 64'd0);
      chk("no_req_in_burst", 64'(bus.l2_req_o), 64'd0);
      clk_step();
    end
    bus.l2_rvalid_i = 1'b0;
    #1;
    chk("done", 64'(done_of(e.id)), 64'd1);
    chk("oth_done", 64'(done_of(!e.id)), 64'd0);
    chk("err_at_done", 64'(bus.err_o), 64'd0);
    chk("req_at_done", 64'(bus.l2_req_o), 64'd0);
    drop(e.id);
    clk_step();
    chk("gnt_cycles", 64'(g_cnt[e.id] - g0[e.id]),
        64'(BEATS));
    chk("oth_gnt_cycles",
        64'(g_cnt[!e.id] - g0[!e.id]), 64'd0);
    chk("done_pulses", 64'(d_cnt[e.id] - d0[e.id]),
        64'd1);
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_l2_req"}, 64'(bus.l2_req_o), 64'd0);
    chk({nm, "_addr"}, 64'(bus.l2_addr_o), 64'd0);
    chk({nm, "_gnt"},
        {bus.ic_grant_o, bus.dc_grant_o}, 64'd0);
    chk({nm, "_done"},
        {bus.ic_done_o, bus.dc_done_o}, 64'd0);
    chk({nm, "_err"}, 64'(bus.err_o), 64'd0);
  endtask

  initial begin
    bit ab;
    fill_vec_t v;
    int e0;
    int d0;

    vec[0] = '{1, 1, 32'h2000, 32'h3000, 0, 0};
    vec[1] = '{1, 1, 32'h2040, 32'h3040, 1, 0};
    vec[2] = '{1, 0, 32'h1000, 32'h0,    2, 0};
    vec[3] = '{0, 1, 32'h0,    32'h4000, 1, 0};
    vec[4] = '{1, 1, 32'h5000, 32'h6000, 3, 0};
    vec[5] = '{1, 0, 32'h7000, 32'h0,    0, 0};
    vec[6] = '{1, 1, 32'h7100, 32'h7200, 1, 1};

    rst_n = 1'b0;
    bus.ic_req_i    = 1'b0;
    bus.dc_req_i    = 1'b0;
    bus.ic_addr_i   = '0;
    bus.dc_addr_i   = '0;
    bus.l2_ack_i    = 1'b0;
    bus.l2_rvalid_i = 1'b0;
    bus.l2_rdata_i  = '0;
    #3;
    chk_all_zero("reset");
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // rvalid while idle: no grant, stays idle
    clk_step();
    bus.l2_rvalid_i = 1'b1;
    #1;
    chk("idle_rvalid_gnt",
        {bus.ic_grant_o, bus.dc_grant_o}, 64'd0);
    clk_step();
    bus.l2_rvalid_i = 1'b0;
    #1;
    chk("idle_rvalid_req", 64'(bus.l2_req_o), 64'd0);
    clk_step();
    chk("idle_rvalid_req2", 64'(bus.l2_req_o), 64'd0);

    for (int r = 0; r < 7; r++) begin
      v = vec[r];
      bus.ic_req_i  = v.ic;
      bus.dc_req_i  = v.dc;
      bus.ic_addr_i = v.ic_addr;
      bus.dc_addr_i = v.dc_addr;
      if (v.ic && v.dc) begin
        if (v.first_dc) begin
          sb.push_back('{1'b1, v.dc_addr});
          sb.push_back('{1'b0, v.ic_addr});
        end else begin
          sb.push_back('{1'b0, v.ic_addr});
          sb.push_back('{1'b1, v.dc_addr});
        end
      end else if (v.ic) begin
        sb.push_back('{1'b0, v.ic_addr});
      end else begin
        sb.push_back('{1'b1, v.dc_addr});
      end
      serve(v.ack, -1, -1, -1, ab);
      if (v.ic && v.dc) serve(v.ack, -1, -1, -1, ab);
    end

    // Gap after beat 3 with both pending: pointer is
    // on DC and must stay there after the abort.
    bus.ic_req_i  = 1'b1;
    bus.dc_req_i  = 1'b1;
    bus.ic_addr_i = 32'h8000;
    bus.dc_addr_i = 32'h8800;
    d0 = d_cnt[1];
    sb.push_back('{1'b1, 32'h8800});
    serve(1, 3, -1, -1, ab);
    chk("gap_aborted", 64'(ab), 64'd1);
    chk("gap_no_done", 64'(d_cnt[1] - d0), 64'd0);
    sb.push_back('{1'b1, 32'h8800});
    sb.push_back('{1'b0, 32'h8000});
    serve(0, -1, -1, -1, ab);
    serve(0, -1, -1, -1, ab);

    // DC raised mid IC burst waits for ic_done;
    // DC drops its request mid fill yet still gets done.
    bus.ic_req_i  = 1'b1;
    bus.ic_addr_i = 32'h9000;
    bus.dc_addr_i = 32'ha000;
    sb.push_back('{1'b0, 32'h9000});
    serve(1, -1, 2, -1, ab);
    #1;
    chk("dc_wait_after_done", 64'(bus.l2_req_o),
        64'd0);
    sb.push_back('{1'b1, 32'ha000});
    serve(0, -1, -1, 4, ab);

    // Reset during beat 5.
    bus.ic_req_i  = 1'b1;
    bus.ic_addr_i = 32'hb000;
    for (int i = 0; i < 10 && !bus.l2_req_o; i++) begin
      clk_step();
    end
    chk("rst_seq_req", 64'(bus.l2_req_o), 64'd1);
    bus.l2_ack_i = 1'b1;
    clk_step();
    bus.l2_ack_i = 1'b0;
    for (int b = 0; b < 5; b++) begin
      bus.l2_rvalid_i = 1'b1;
      clk_step();
    end
    #1;
    chk("beat5_gnt", 64'(bus.ic_grant_o), 64'd1);
    e0 = e_cnt;
    d0 = d_cnt[0] + d_cnt[1];
    rst_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    bus.l2_rvalid_i = 1'b0;
    clk_step();
    clk_step();
    rst_n = 1'b1;
    sb.push_back('{1'b0, 32'hb000});
    serve(2, -1, -1, -1, ab);
    chk("rst_no_err", 64'(e_cnt - e0), 64'd0);
    chk("rst_one_done",
        64'(d_cnt[0] + d_cnt[1] - d0), 64'd1);

    chk("onehot_viol", 64'(oh_viol), 64'd0);
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/l2_fill_arbiter.md
L2_FILL_ARBITER -- requirements
Module: l2_fill_arbiter

Interface
REQ-001 SHALL have parameter BEATS, default 8, meaning 64-bit beats per line fill (B/8 for B=64).
REQ-002 SHALL have parameter ADDR_W, default 32, meaning fill address width.
REQ-003 SHALL have port clk_i, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_ni, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port ic_req_i, input, 1, instruction-cache miss fill request, held high until ic_done_o.
REQ-006 SHALL have port ic_addr_i, input, ADDR_W, instruction-cache line address.
REQ-007 SHALL have port dc_req_i, input, 1, data-cache fill request, held high until dc_done_o.
REQ-008 SHALL have port dc_addr_i, input, ADDR_W, data-cache line address.
REQ-009 SHALL have port ic_grant_o, output, 1, per-beat write enable to the instruction cache set (drives ic_repl_grant_i).
REQ-010 SHALL have port dc_grant_o, output, 1, per-beat write enable to the data cache.
REQ-011 SHALL have port ic_done_o / dc_done_o, output, 1 each, one-cycle fill-complete pulse.
REQ-012 SHALL have port l2_req_o, output, 1, request to L2; l2_addr_o, output, ADDR_W, line address.
REQ-013 SHALL have port l2_ack_i, input, 1, L2 accepts request in the cycle l2_req_o && l2_ack_i.
REQ-014 SHALL have port l2_rvalid_i, input, 1, and l2_rdata_i, input, 64, L2 return beat.
REQ-015 SHALL have port fill_data_o, output, 64, combinational copy of l2_rdata_i to both caches.
REQ-016 SHALL have port err_o, output, 1, one-cycle pulse on aborted burst.

Function
REQ-017 SHALL implement FSM IDLE -> REQ -> WAIT -> BURST -> IDLE.
REQ-018 IDLE: if any request pending, SHALL select owner, latch its address, go to REQ next cycle.
REQ-019 Arbitration SHALL be round-robin: single request wins; both pending -> priority-pointer side wins; pointer moves to the other side on each completed fill.
REQ-020 REQ: l2_req_o=1 with latched l2_addr_o; SHALL hold both stable until l2_ack_i, then go to WAIT.
REQ-021 WAIT: on first l2_rvalid_i go to BURST, counting that beat as beat 0.
REQ-022 Owner grant SHALL equal l2_rvalid_i && (state WAIT or BURST); non-owner grant SHALL be 0.
REQ-023 Beat counter, $clog2(BEATS) bits, SHALL increment per valid beat; on beat BEATS-1, owner done pulses next cycle and FSM returns to IDLE.
REQ-024 Beats SHALL be contiguous; l2_rvalid_i low in BURST -> err_o pulse, grant low, counter cleared, pointer unchanged, IDLE; owner re-arbitrates with request still high.
REQ-025 Request deasserted mid-fill SHALL be ignored; fill completes and done still pulses.
REQ-026 Request arriving during a fill SHALL wait; earliest re-grant is the cycle after done.
REQ-027 l2_rvalid_i in IDLE or REQ SHALL be ignored; no grant.
REQ-028 At most one of ic_grant_o, dc_grant_o SHALL be high in any cycle.

Reset
REQ-029 reset_ni low SHALL immediately force state IDLE, counter 0, pointer to instruction side, latched address 0, and all outputs except fill_data_o to 0.
REQ-030 Reset mid-fill SHALL abandon the fill without done or err pulses.

Structure
REQ-031 Shared package SHALL hold fill FSM state enum (IDLE, REQ, WAIT, BURST) and requester-ID enum (IC, DC).
REQ-032 A sub-module rr_arbiter2 (two requests, pointer, one-hot grant) is natural; rest flat.

Verification
REQ-033 ic_req_i alone, addr 0x1000, ack after 2 cycles, 8 contiguous beats -> l2_addr_o=0x1000, ic_grant_o high exactly 8 cycles, ic_done_o one pulse, dc_grant_o never high.
REQ-034 ic and dc requests same cycle after reset -> IC served first, then DC; next simultaneous pair -> IC served first again.
REQ-035 rvalid gap after beat 3 -> err_o pulse, no done, new l2_req_o with same address, then full 8-beat fill and done.
REQ-036 dc_req_i raised during IC burst -> DC request issued after ic_done_o, never earlier.
REQ-037 reset_ni low during beat 5 -> outputs 0 immediately; next request restarts from REQ with counter 0.
REQ-038 l2_rvalid_i pulsed while IDLE -> no grant, no state change.
